// File: rtl/mips_isa_pkg.sv
// Shared MIPS ISA definitions for the instruction encoder and the main
// control decoder.
//   - OP_*     : primary opcodes, instruction bits [31:26]
//   - FUNCT_*  : R-type function codes, instruction bits [5:0]
//   - kind_e   : 3-bit symbolic instruction kind on the encoder input stream
//                (values 6 and 7 are illegal and have no name)
//   - state_e  : encoder session states
//   - is_branch: true for kinds that carry a delay slot (BEQ, J)
package mips_isa_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  typedef enum logic [2:0] {
    KIND_R    = 3'd0,
    KIND_LW   = 3'd1,
    KIND_SW   = 3'd2,
    KIND_BEQ  = 3'd3,
    KIND_ADDI = 3'd4,
    KIND_J    = 3'd5
  } kind_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic logic is_branch(input kind_e kind);
    return (kind == KIND_BEQ) || (kind == KIND_J);
  endfunction

endpackage

// File: rtl/mips_instr_pack.sv
// Combinational packer: turns one symbolic instruction into its 32-bit MIPS
// word. Fields a kind does not use are ignored; shamt is always 0.
// Ports:
//   i_kind   : instruction kind (kind_e encoding, 6..7 illegal)
//   i_rs/i_rt/i_rd, i_funct, i_imm, i_target : instruction fields
//   o_word   : packed instruction (0 when illegal)
//   o_illegal: kind is not one of the six supported kinds
module mips_instr_pack
  import mips_isa_pkg::*;
(
  input  logic [2:0]  i_kind,
  input  logic [4:0]  i_rs,
  input  logic [4:0]  i_rt,
  input  logic [4:0]  i_rd,
  input  logic [5:0]  i_funct,
  input  logic [15:0] i_imm,
  input  logic [25:0] i_target,
  output logic [31:0] o_word,
  output logic        o_illegal
);

  // Field packing per kind; anything outside the named kinds is flagged.
  always_comb begin
    o_word    = '0;
    o_illegal = 1'b0;
    case (kind_e'(i_kind))
      KIND_R:    o_word = {OP_RTYPE, i_rs, i_rt, i_rd, 5'd0, i_funct};
      KIND_LW:   o_word = {OP_LW,   i_rs, i_rt, i_imm};
      KIND_SW:   o_word = {OP_SW,   i_rs, i_rt, i_imm};
      KIND_BEQ:  o_word = {OP_BEQ,  i_rs, i_rt, i_imm};
      KIND_ADDI: o_word = {OP_ADDI, i_rs, i_rt, i_imm};
      KIND_J:    o_word = {OP_J,    i_target};
      default:   o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_instr_encoder.sv
// Sequential instruction encoder: accepts symbolic instructions on a
// valid/ready stream, packs them and writes them into instruction memory at
// consecutive word addresses starting at BASE_ADDR.
// Optional build macro: DELAY_SLOT_NOP_EN -- write a NOP after every BEQ/J.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   start                 : begin a session (only seen in IDLE)
//   in_valid / in_ready   : beat handshake; in_kind + field inputs, in_last
//   imem_we/addr/wdata    : registered memory write port, one cycle after accept
//   busy                  : session in progress (state != IDLE)
//   done                  : one-cycle pulse at session end
//   count                 : words written this session
//   err                   : sticky illegal-kind / overflow flag, cleared on start
module mips_instr_encoder
  import mips_isa_pkg::*;
#(
  parameter int ADDR_W    = 6,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_kind,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [5:0]        in_funct,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count,
  output logic              err
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(2 ** ADDR_W);

`ifdef DELAY_SLOT_NOP_EN
  localparam bit NOP_EN = 1'b1;
`else
  localparam bit NOP_EN = 1'b0;
`endif

  state_e            r_state, w_state;
  logic [ADDR_W-1:0] r_ptr, w_ptr;
  logic [CNT_W-1:0]  r_count, w_count;
  logic              r_err, w_err;
  logic              r_we, w_we;
  logic [ADDR_W-1:0] r_addr, w_addr;
  logic [31:0]       r_wdata, w_wdata;
  logic              r_nopPend, w_nopPend;
  logic              r_lastPend, w_lastPend;

  logic [31:0]       w_word;
  logic              w_illegal;
  logic              w_needNop;

  mips_instr_pack u_pack (
    .i_kind    (in_kind),
    .i_rs      (in_rs),
    .i_rt      (in_rt),
    .i_rd      (in_rd),
    .i_funct   (in_funct),
    .i_imm     (in_imm),
    .i_target  (in_target),
    .o_word    (w_word),
    .o_illegal (w_illegal)
  );

  assign w_needNop = NOP_EN && !w_illegal && is_branch(kind_e'(in_kind));

  // Next-state logic. Every write is scheduled here and appears on the
  // memory port one cycle later. A pending delay-slot NOP blocks new beats
  // for one cycle; a branch that was also the last beat parks in LOAD
  // (r_lastPend) so its NOP goes out before DRAIN.
  always_comb begin
    w_state    = r_state;
    w_ptr      = r_ptr;
    w_count    = r_count;
    w_err      = r_err;
    w_we       = 1'b0;
    w_addr     = r_addr;
    w_wdata    = r_wdata;
    w_nopPend  = r_nopPend;
    w_lastPend = r_lastPend;
    in_ready   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state    = ST_LOAD;
          w_ptr      = ADDR_W'(BASE_ADDR);
          w_count    = '0;
          w_err      = 1'b0;
          w_nopPend  = 1'b0;
          w_lastPend = 1'b0;
        end
      end
      ST_LOAD: begin
        if (r_nopPend) begin
          w_nopPend  = 1'b0;
          w_lastPend = 1'b0;
          if (r_count < DEPTH) begin
            w_we    = 1'b1;
            w_addr  = r_ptr;
            w_wdata = '0;
            w_ptr   = r_ptr + ADDR_W'(1);
            w_count = r_count + CNT_W'(1);
          end else begin
            w_err = 1'b1;
          end
          if (r_lastPend) w_state = ST_DRAIN;
        end else if (r_count >= DEPTH) begin
          // Memory full without a last beat: abandon the session.
          w_err   = 1'b1;
          w_state = ST_DRAIN;
        end else begin
          in_ready = 1'b1;
          if (in_valid) begin
            if (w_illegal) begin
              w_err = 1'b1;
            end else begin
              w_we      = 1'b1;
              w_addr    = r_ptr;
              w_wdata   = w_word;
              w_ptr     = r_ptr + ADDR_W'(1);
              w_count   = r_count + CNT_W'(1);
              w_nopPend = w_needNop;
            end
            if (in_last) begin
              if (w_needNop) w_lastPend = 1'b1;
              else           w_state    = ST_DRAIN;
            end
          end
        end
      end
      ST_DRAIN: w_state = ST_DONE;
      ST_DONE:  w_state = ST_IDLE;
      default:  w_state = ST_IDLE;
    endcase
  end

  // State and write-port registers; reset abandons any session in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_ptr      <= ADDR_W'(BASE_ADDR);
      r_count    <= '0;
      r_err      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_nopPend  <= 1'b0;
      r_lastPend <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_ptr      <= w_ptr;
      r_count    <= w_count;
      r_err      <= w_err;
      r_we       <= w_we;
      r_addr     <= w_addr;
      r_wdata    <= w_wdata;
      r_nopPend  <= w_nopPend;
      r_lastPend <= w_lastPend;
    end
  end

  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign busy       = (r_state != ST_IDLE);
  assign done       = (r_state == ST_DONE);
  assign count      = r_count;
  assign err        = r_err;

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Self-checking bench for mips_instr_encoder: table-driven single-beat
// sessions, hand-written multi-cycle sequences, and randomized sessions
// checked against a transaction-level reference model.
module tb_mips_instr_encoder;

  localparam int ADDR_W = 6;
  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int BASE   = 0;

`ifdef DELAY_SLOT_NOP_EN
  localparam bit NOP_EN = 1'b1;
`else
  localparam bit NOP_EN = 1'b0;
`endif

  logic              clk, reset, start, in_valid, in_ready, in_last;
  logic [2:0]        in_kind;
  logic [4:0]        in_rs, in_rt, in_rd;
  logic [5:0]        in_funct;
  logic [15:0]       in_imm;
  logic [25:0]       in_target;
  logic              imem_we, busy, done, err;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   count;

  mips_instr_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_funct(in_funct),
    .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .done(done), .count(count), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  kind;
    logic [4:0]  rs, rt, rd;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;
    logic        last;
  } beat_t;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    int                cyc;
  } wr_t;

  typedef struct {
    logic [2:0]  kind;
    logic [4:0]  rs, rt, rd;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;
    logic [31:0] expWord;
    logic        expIllegal;
  } vec_t;

  beat_t stim[$];
  wr_t   gotQ[$];
  wr_t   expQ[$];
  int    checks = 0, errors = 0, cyc = 0, doneCnt = 0, stallCnt = 0;
  bit    bubbleEn = 0;

  // Watchdog: the bench never hangs.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Monitor: collect memory writes and done pulses away from the active edge.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (imem_we) gotQ.push_back('{imem_addr, imem_wdata, cyc});
    if (done) doneCnt = doneCnt + 1;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic beat_t mkBeat(input int k, input int rs, input int rt, input int rd,
                                   input int f, input int imm, input int t, input bit last);
    beat_t b;
    b.kind = 3'(k); b.rs = 5'(rs); b.rt = 5'(rt); b.rd = 5'(rd);
    b.funct = 6'(f); b.imm = 16'(imm); b.target = 26'(t); b.last = last;
    return b;
  endfunction

  function automatic beat_t randBeat(input bit allowIllegal, input bit last);
    int k;
    k = (allowIllegal && $urandom_range(0, 7) == 0) ? $urandom_range(6, 7) : $urandom_range(0, 5);
    return mkBeat(k, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, last);
  endfunction

  // Reference encoding straight from the ISA field layout.
  function automatic logic [31:0] encode(input beat_t b);
    longint unsigned rs, rt, rd, f, imm, t, op;
    rs = b.rs; rt = b.rt; rd = b.rd; f = b.funct; imm = b.imm; t = b.target;
    case (b.kind)
      3'd0: op = 0;
      3'd1: op = 35;
      3'd2: op = 43;
      3'd3: op = 4;
      3'd4: op = 8;
      default: op = 2;
    endcase
    if (b.kind == 3'd0) return 32'(rs * 2**21 + rt * 2**16 + rd * 2**11 + f);
    if (b.kind == 3'd5) return 32'(op * 2**26 + t);
    return 32'(op * 2**26 + rs * 2**21 + rt * 2**16 + imm);
  endfunction

  // Transaction-level model of one session over the current stimulus list.
  task automatic modelSession(output int expAcc, output int expCnt, output bit expErr);
    int cnt; bit ended;
    cnt = 0; expErr = 0; expAcc = 0; ended = 0;
    expQ.delete();
    foreach (stim[i]) begin
      if (cnt >= DEPTH) begin expErr = 1; ended = 1; break; end
      expAcc++;
      if (stim[i].kind > 3'd5) expErr = 1;
      else begin
        expQ.push_back('{ADDR_W'(BASE + cnt), encode(stim[i]), 0});
        cnt++;
        if (NOP_EN && (stim[i].kind == 3'd3 || stim[i].kind == 3'd5)) begin
          if (cnt < DEPTH) begin expQ.push_back('{ADDR_W'(BASE + cnt), 32'h0, 0}); cnt++; end
          else expErr = 1;
        end
      end
      if (stim[i].last) begin ended = 1; break; end
    end
    if (!ended && cnt >= DEPTH) expErr = 1;
    expCnt = cnt;
  endtask

  task automatic driveBeat(input beat_t b);
    in_kind = b.kind; in_rs = b.rs; in_rt = b.rt; in_rd = b.rd; in_funct = b.funct;
    in_imm = b.imm; in_target = b.target; in_last = b.last;
  endtask

  task automatic startSession();
    gotQ.delete(); doneCnt = 0;
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
  endtask

  // Runs one full session from the stimulus list; returns beats accepted.
  task automatic applyStimulus(output int accepted);
    int idx, stall;
    idx = 0; stall = 0; stallCnt = 0;
    startSession();
    checkOutput("start_clears_err", err, 0);
    checkOutput("start_clears_count", count, 0);
    while (idx < stim.size() && stall < 8) begin
      if (bubbleEn && $urandom_range(0, 3) == 0) in_valid = 0;
      else begin
        driveBeat(stim[idx]);
        in_valid = 1;
        if (in_ready) begin idx++; stall = 0; end
        else begin stall++; stallCnt++; end
      end
      @(negedge clk);
    end
    in_valid = 0;
    accepted = idx;
    for (int i = 0; i < 20 && busy; i++) @(negedge clk);
    checkOutput("session_ends", busy, 0);
  endtask

  task automatic runAndCheck(input string tag);
    int acc, expAcc, expCnt; bit expErr;
    modelSession(expAcc, expCnt, expErr);
    applyStimulus(acc);
    checkOutput({tag, "_accepted"}, acc, expAcc);
    checkOutput({tag, "_nwrites"}, gotQ.size(), expQ.size());
    for (int i = 0; i < expQ.size() && i < gotQ.size(); i++) begin
      checkOutput($sformatf("%s_addr%0d", tag, i), gotQ[i].addr, expQ[i].addr);
      checkOutput($sformatf("%s_data%0d", tag, i), gotQ[i].data, expQ[i].data);
    end
    checkOutput({tag, "_count"}, count, expCnt);
    checkOutput({tag, "_err"}, err, expErr);
    checkOutput({tag, "_done_pulses"}, doneCnt, 1);
  endtask

  vec_t vecs[10];

  initial begin
    int nExp, seen;
    vecs[0] = '{3'd0, 5'd1,  5'd2,  5'd3,  6'h20, 16'hABCD, 26'h155,     32'h00221820, 1'b0};
    vecs[1] = '{3'd1, 5'd9,  5'd8,  5'd17, 6'h3F, 16'h0004, 26'h3FFFFFF, 32'h8D280004, 1'b0};
    vecs[2] = '{3'd2, 5'd29, 5'd31, 5'd0,  6'h11, 16'hFFFC, 26'h1234,    32'hAFBFFFFC, 1'b0};
    vecs[3] = '{3'd3, 5'd1,  5'd2,  5'd5,  6'h01, 16'hFFFF, 26'h0,       32'h1022FFFF, 1'b0};
    vecs[4] = '{3'd4, 5'd0,  5'd5,  5'd9,  6'h2A, 16'h0007, 26'h2AAAAAA, 32'h20050007, 1'b0};
    vecs[5] = '{3'd5, 5'd7,  5'd7,  5'd7,  6'h07, 16'h7777, 26'h10,      32'h08000010, 1'b0};
    vecs[6] = '{3'd5, 5'd0,  5'd0,  5'd0,  6'h00, 16'h0000, 26'h3FFFFFF, 32'h0BFFFFFF, 1'b0};
    vecs[7] = '{3'd0, 5'd31, 5'd31, 5'd31, 6'h2A, 16'hFFFF, 26'h0,       32'h03FFF82A, 1'b0};
    vecs[8] = '{3'd6, 5'd1,  5'd2,  5'd3,  6'h20, 16'h1234, 26'h10,      32'h0,        1'b1};
    vecs[9] = '{3'd7, 5'd4,  5'd5,  5'd6,  6'h22, 16'h5678, 26'h20,      32'h0,        1'b1};

    reset = 1; start = 0; in_valid = 0;
    driveBeat(mkBeat(0, 0, 0, 0, 0, 0, 0, 0));
    repeat (3) @(negedge clk);
    checkOutput("rst_we", imem_we, 0);
    checkOutput("rst_addr", imem_addr, 0);
    checkOutput("rst_wdata", imem_wdata, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_count", count, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_ready", in_ready, 0);
    reset = 0;
    @(negedge clk);

    // Single-beat sessions from the table.
    foreach (vecs[i]) begin
      int acc;
      stim.delete();
      stim.push_back(mkBeat(vecs[i].kind, vecs[i].rs, vecs[i].rt, vecs[i].rd,
                            vecs[i].funct, vecs[i].imm, vecs[i].target, 1));
      applyStimulus(acc);
      nExp = vecs[i].expIllegal ? 0 : ((NOP_EN && (vecs[i].kind == 3'd3 || vecs[i].kind == 3'd5)) ? 2 : 1);
      checkOutput($sformatf("vec%0d_nwrites", i), gotQ.size(), nExp);
      if (gotQ.size() > 0) begin
        checkOutput($sformatf("vec%0d_word", i), gotQ[0].data, vecs[i].expWord);
        checkOutput($sformatf("vec%0d_addr", i), gotQ[0].addr, 0);
      end
      checkOutput($sformatf("vec%0d_err", i), err, vecs[i].expIllegal);
      checkOutput($sformatf("vec%0d_count", i), count, nExp);
      checkOutput($sformatf("vec%0d_done", i), doneCnt, 1);
    end

    // R beat: write appears exactly one cycle after the accept.
    startSession();
    driveBeat(mkBeat(0, 1, 2, 3, 32, 0, 0, 1));
    in_valid = 1;
    checkOutput("r_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 0;
    checkOutput("r_we", imem_we, 1);
    checkOutput("r_addr", imem_addr, 0);
    checkOutput("r_wdata", imem_wdata, 32'h00221820);
    seen = 0;
    for (int i = 0; i < 6 && seen == 0; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        checkOutput("r_count", count, 1);
        checkOutput("r_err", err, 0);
      end
    end
    checkOutput("r_done_seen", seen, 1);
    for (int i = 0; i < 10 && busy; i++) @(negedge clk);

    // Back-to-back LW, ADDI, J with valid held high.
    bubbleEn = 0;
    stim.delete();
    stim.push_back(mkBeat(1, 9, 8, 0, 0, 4, 0, 0));
    stim.push_back(mkBeat(4, 0, 5, 0, 0, 7, 0, 0));
    stim.push_back(mkBeat(5, 0, 0, 0, 0, 0, 'h10, 1));
    runAndCheck("b2b");
    if (gotQ.size() >= 3) begin
      checkOutput("b2b_w0", gotQ[0].data, 32'h8D280004);
      checkOutput("b2b_w2", gotQ[2].data, 32'h08000010);
      checkOutput("b2b_gap01", gotQ[1].cyc - gotQ[0].cyc, 1);
      checkOutput("b2b_gap12", gotQ[2].cyc - gotQ[1].cyc, 1);
    end
    checkOutput("b2b_count", count, NOP_EN ? 4 : 3);

    // BEQ then SW: delay slot stall only with the NOP feature.
    stim.delete();
    stim.push_back(mkBeat(3, 1, 2, 0, 0, 'hFFFF, 0, 0));
    stim.push_back(mkBeat(2, 3, 4, 0, 0, 8, 0, 1));
    runAndCheck("beq_sw");
    checkOutput("beq_sw_stall", stallCnt, NOP_EN ? 1 : 0);

    // Illegal beat between legal ones; err stays set until the next start.
    stim.delete();
    stim.push_back(mkBeat(4, 1, 2, 0, 0, 3, 0, 0));
    stim.push_back(mkBeat(6, 1, 2, 3, 4, 5, 6, 0));
    stim.push_back(mkBeat(1, 2, 3, 0, 0, 9, 0, 1));
    runAndCheck("illegal");
    repeat (3) @(negedge clk);
    checkOutput("illegal_err_sticky", err, 1);

    // Overflow: more beats than memory words, none marked last.
    stim.delete();
    for (int i = 0; i <= DEPTH; i++) stim.push_back(randBeat(0, 0));
    runAndCheck("overflow");
    checkOutput("overflow_err", err, 1);

    // Reset one cycle after the second accept.
    startSession();
    driveBeat(mkBeat(4, 1, 1, 0, 0, 1, 0, 0));
    in_valid = 1;
    checkOutput("rstseq_ready", in_ready, 1);
    @(negedge clk);
    driveBeat(mkBeat(1, 2, 2, 0, 0, 2, 0, 0));
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    checkOutput("rstseq_we", imem_we, 0);
    checkOutput("rstseq_addr", imem_addr, 0);
    checkOutput("rstseq_wdata", imem_wdata, 0);
    checkOutput("rstseq_busy", busy, 0);
    checkOutput("rstseq_count", count, 0);
    checkOutput("rstseq_err", err, 0);
    checkOutput("rstseq_ready", in_ready, 0);
    reset = 0;
    repeat (4) @(negedge clk);
    in_valid = 0;
    checkOutput("rstseq_no_more_writes", gotQ.size(), 2);
    stim.delete();
    stim.push_back(mkBeat(0, 4, 5, 6, 'h22, 0, 0, 0));
    stim.push_back(mkBeat(4, 7, 8, 0, 0, 'h100, 0, 1));
    runAndCheck("after_rst");

    // Randomized sessions with valid bubbles.
    bubbleEn = 1;
    for (int s = 0; s < 20; s++) begin
      int n;
      n = $urandom_range(1, 10);
      stim.delete();
      for (int i = 0; i < n; i++) stim.push_back(randBeat(1, i == n - 1));
      runAndCheck($sformatf("rand%0d", s));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
